// File: rtl/fp16_add_sched_if.sv
// Bundle of requester, shared-adder and response signals around fp16_add_sched.
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface fp16_add_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 add_start;
  logic [15:0]          add_a;
  logic [15:0]          add_b;
  logic                 add_done;
  logic [15:0]          add_sum;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
    output req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
    input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler sharing one multi-cycle FP16 adder among NREQ requesters,
// with a watchdog that substitutes a flagged qNaN when the adder never answers.
module fp16_add_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             nrst,
  fp16_add_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  WDOG_LIMIT = 8'(TIMEOUT);
  localparam logic [15:0] QNAN       = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_grant;
  logic [PW-1:0]   w_grant;
  logic            w_any_valid;
  logic [7:0]      r_wdog;
  logic [7:0]      w_wdog_inc;
  logic            w_timeout;
  logic [15:0]     r_add_a;
  logic [15:0]     r_add_b;
  logic [15:0]     r_rsp_data;
  logic            r_rsp_err;
  int              w_lane;

  // Scan offsets from the highest down so the smallest offset from rr_ptr is the
  // last writer and therefore wins.
  always_comb begin
    int idx;
    w_grant     = '0;
    w_any_valid = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(r_rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        w_grant     = PW'(idx);
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_lane = int'(w_grant);

  // The counter holds the number of WAIT cycles already elapsed, so the adder gets
  // exactly TIMEOUT cycles after add_start; the incremented value flags the last one.
  assign w_wdog_inc = r_wdog + 8'd1;
  assign w_timeout  = (w_wdog_inc == WDOG_LIMIT);

  // NOTE: asynchronous active-low reset lives only in the sensitivity list of
  // sequential blocks; state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_next  = r_state;
    bus.req_ready = '0;
    bus.add_start = 1'b0;
    bus.rsp_valid = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          bus.req_ready[w_grant] = nrst;
          w_state_next           = ISSUE;
        end
      end
      ISSUE: begin
        bus.add_start = 1'b1;
        w_state_next  = WAIT;
      end
      WAIT: begin
        if (bus.add_done || w_timeout) w_state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid[r_grant] = 1'b1;
        if (bus.rsp_ready[r_grant]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_wdog     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_add_a <= bus.req_a[16*w_lane +: 16];
            r_add_b <= bus.req_b[16*w_lane +: 16];
            r_grant <= w_grant;
          end
        end
        ISSUE: r_wdog <= '0;
        WAIT: begin
          r_wdog <= w_wdog_inc;
          // A completion on the final watchdog cycle still counts as a real result.
          if (bus.add_done) begin
            r_rsp_data <= bus.add_sum;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= QNAN;
            r_rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[r_grant])
            r_rr_ptr <= (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.add_a    = r_add_a;
  assign bus.add_b    = r_add_b;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_fp16_add_sched.sv
// Directed bench for fp16_add_sched: each task drives one scenario and checks
// the scheduler's outputs against hand-computed values.
module tb_fp16_add_sched;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] lane_a [NREQ];
  logic [15:0] lane_b [NREQ];

  fp16_add_sched_if #(.NREQ(NREQ)) bus ();

  fp16_add_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = '0;
    bus.add_done  = 1'b0;
    bus.add_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[16*i +: 16] = lane_a[i];
      bus.req_b[16*i +: 16] = lane_b[i];
    end
    repeat (2) tick();
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.add_start !== 1'b0) begin n_fail++; $display("FAIL reset_add_start got=%b exp=0", bus.add_start); end
    n_checks++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
    n_checks++; if ({bus.add_a, bus.add_b} !== 32'h0) begin n_fail++; $display("FAIL reset_operands got=%h exp=00000000", {bus.add_a, bus.add_b}); end
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== 17'h0) begin n_fail++; $display("FAIL reset_rsp got=%h exp=00000", {bus.rsp_err, bus.rsp_data}); end
    bus.req_valid = '0;
    nrst = 1'b1;
    tick();
  endtask

  // Requester 0 adds 1.0 + 1.0; the adder answers 2.0 three cycles after add_start.
  task automatic test_single_op();
    bus.req_valid = 4'b0001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.add_start !== 1'b1) begin n_fail++; $display("FAIL single_add_start got=%b exp=1", bus.add_start); end
    n_checks++; if ({bus.add_a, bus.add_b} !== 32'h3C00_3C00) begin n_fail++; $display("FAIL single_operands got=%h exp=3c003c00", {bus.add_a, bus.add_b}); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    tick();
    n_checks++; if (bus.add_start !== 1'b0) begin n_fail++; $display("FAIL single_start_one_cycle got=%b exp=0", bus.add_start); end
    repeat (2) tick();
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h4000;
    #1;
    n_checks++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_early got=%b exp=0000", bus.rsp_valid); end
    tick();
    bus.add_done = 1'b0;
    n_checks++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=0001", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'h4000}) begin n_fail++; $display("FAIL single_rsp_data got=%h exp=04000", {bus.rsp_err, bus.rsp_data}); end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    n_checks++; if ({bus.busy, bus.rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL single_back_idle got=%b exp=00000", {bus.busy, bus.rsp_valid}); end
  endtask

  // rr_ptr is 1 here: requesters 0 and 1 ask, 1 wins, and the adder stays silent.
  task automatic test_timeout();
    bus.req_valid = 4'b0011;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL timeout_req_ready got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.add_start !== 1'b1) begin n_fail++; $display("FAIL timeout_add_start got=%b exp=1", bus.add_start); end
    repeat (TO) tick();
    n_checks++; if ({bus.busy, bus.rsp_valid} !== 5'b10000) begin n_fail++; $display("FAIL timeout_still_waiting got=%b exp=10000", {bus.busy, bus.rsp_valid}); end
    tick();
    n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL timeout_rsp_valid got=%b exp=0010", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 16'h7E00}) begin n_fail++; $display("FAIL timeout_rsp_data got=%h exp=17e00", {bus.rsp_err, bus.rsp_data}); end
    bus.rsp_ready = 4'b1101;
    tick();
    n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL timeout_other_ready got=%b exp=0010", bus.rsp_valid); end
    bus.rsp_ready = 4'b0010;
    tick();
    bus.rsp_ready = '0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_accept got=%b exp=0", bus.busy); end
    bus.req_valid = 4'b1111;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL timeout_rr_advance got=%b exp=0100", bus.req_ready); end
    bus.req_valid = '0;
    #1;
  endtask

  // add_done lands on the very cycle the watchdog would expire.
  task automatic test_tie();
    bus.req_valid = 4'b0100;
    #1;
    tick();
    bus.req_valid = '0;
    repeat (TO) tick();
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h4200;
    tick();
    bus.add_done = 1'b0;
    n_checks++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL tie_rsp_valid got=%b exp=0100", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'h4200}) begin n_fail++; $display("FAIL tie_rsp_data got=%h exp=04200", {bus.rsp_err, bus.rsp_data}); end
    bus.rsp_ready = 4'b0100;
    tick();
    bus.rsp_ready = '0;
  endtask

  // Requester 3 is served, then its response is held off while everything else pushes.
  task automatic test_backpressure();
    bus.req_valid = 4'b1000;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_req_ready got=%b exp=1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_checks++; if ({bus.add_a, bus.add_b} !== {lane_a[3], lane_b[3]}) begin n_fail++; $display("FAIL bp_operands got=%h exp=%h", {bus.add_a, bus.add_b}, {lane_a[3], lane_b[3]}); end
    repeat (2) tick();
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h4500;
    tick();
    bus.add_sum   = 16'hBEEF;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1000", i, bus.rsp_valid); end
      n_checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'h4500}) begin n_fail++; $display("FAIL bp_rsp_data[%0d] got=%h exp=04500", i, {bus.rsp_err, bus.rsp_data}); end
      n_checks++; if ({bus.req_ready, bus.add_start} !== 5'b0) begin n_fail++; $display("FAIL bp_quiet[%0d] got=%b exp=00000", i, {bus.req_ready, bus.add_start}); end
      tick();
    end
    bus.add_done  = 1'b0;
    bus.rsp_ready = 4'b1000;
    tick();
    bus.rsp_ready = '0;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL b2b_next_ready got=%b exp=0001", bus.req_ready); end
    n_checks++; if (bus.add_a !== lane_a[3]) begin n_fail++; $display("FAIL b2b_add_a_hold got=%h exp=%h", bus.add_a, lane_a[3]); end
    tick();
    bus.req_valid = '0;
    n_checks++; if ({bus.add_start, bus.add_a} !== {1'b1, lane_a[0]}) begin n_fail++; $display("FAIL b2b_issue got=%h exp=%h", {bus.add_start, bus.add_a}, {1'b1, lane_a[0]}); end
    tick();
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h1234;
    tick();
    bus.add_done = 1'b0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b0001, 16'h1234}) begin n_fail++; $display("FAIL b2b_rsp got=%h exp=11234", {bus.rsp_valid, bus.rsp_data}); end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
  endtask

  // rr_ptr is 1 here; reset mid-WAIT must drop the operation and restart from index 0.
  task automatic test_reset_in_wait();
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rstw_req_ready got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (2) tick();
    nrst = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    n_checks++; if ({bus.busy, bus.add_start, bus.rsp_valid, bus.req_ready} !== 10'b0) begin n_fail++; $display("FAIL rstw_outputs got=%b exp=0000000000", {bus.busy, bus.add_start, bus.rsp_valid, bus.req_ready}); end
    n_checks++; if (bus.add_a !== 16'h0) begin n_fail++; $display("FAIL rstw_add_a got=%h exp=0000", bus.add_a); end
    tick();
    bus.req_valid = '0;
    nrst = 1'b1;
    tick();
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h4000;
    tick();
    bus.add_done = 1'b0;
    n_checks++; if ({bus.busy, bus.rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL rstw_late_done got=%b exp=00000", {bus.busy, bus.rsp_valid}); end
    bus.req_valid = 4'b1111;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstw_grant_from_0 got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    #1;
  endtask

  // All four request continuously and accept at once: grants must rotate 0,1,2,3,0.
  task automatic test_fairness();
    logic [3:0]  exp_oh;
    logic [15:0] exp_sum;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh  = 4'b0001 << (k % 4);
      exp_sum = 16'h5000 + 16'(k);
      #1;
      n_checks++; if (bus.req_ready !== exp_oh) begin n_fail++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_oh); end
      tick();
      n_checks++; if ({bus.add_start, bus.add_a, bus.add_b} !== {1'b1, lane_a[k%4], lane_b[k%4]}) begin n_fail++; $display("FAIL fair_issue[%0d] got=%h exp=%h", k, {bus.add_start, bus.add_a, bus.add_b}, {1'b1, lane_a[k%4], lane_b[k%4]}); end
      tick();
      bus.add_done = 1'b1;
      bus.add_sum  = exp_sum;
      tick();
      bus.add_done = 1'b0;
      n_checks++; if ({bus.rsp_valid, bus.rsp_data} !== {exp_oh, exp_sum}) begin n_fail++; $display("FAIL fair_rsp[%0d] got=%h exp=%h", k, {bus.rsp_valid, bus.rsp_data}, {exp_oh, exp_sum}); end
      tick();
      if (k == 4) bus.req_valid = '0;
    end
    bus.rsp_ready = '0;
  endtask

  initial begin
    lane_a[0] = 16'h3C00; lane_b[0] = 16'h3C00;
    lane_a[1] = 16'h1001; lane_b[1] = 16'h2001;
    lane_a[2] = 16'h1002; lane_b[2] = 16'h2002;
    lane_a[3] = 16'h1003; lane_b[3] = 16'h2003;
    test_reset();
    test_single_op();
    test_timeout();
    test_tie();
    test_backpressure();
    test_reset_in_wait();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached without completing the test sequence");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fp16_add_sched.md
FP16_ADD_SCHED -- requirements
Module: fp16_add_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder, range 2..8.
REQ-002 Parameter TIMEOUT, default 16: adder watchdog limit in cycles, range 2..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  16*NREQ  FP16 operand A; requester i uses bits [16i+15:16i].
REQ-007 req_b  input  16*NREQ  FP16 operand B; same packing as req_a.
REQ-008 req_ready  output  NREQ  accept strobe, one-hot or zero.
REQ-009 add_start  output  1  one-cycle start pulse to the shared FP16 adder.
REQ-010 add_a  output  16  latched operand A to the adder.
REQ-011 add_b  output  16  latched operand B to the adder.
REQ-012 add_done  input  1  adder completion pulse.
REQ-013 add_sum  input  16  adder result, valid when add_done=1.
REQ-014 rsp_valid  output  NREQ  one-hot response valid to the granted requester.
REQ-015 rsp_ready  input  NREQ  per-requester response accept.
REQ-016 rsp_data  output  16  result, shared by all requesters.
REQ-017 rsp_err  output  1  qualifies rsp_data as a timeout result.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 Arbitration: round-robin pointer rr_ptr (log2 NREQ bits); grant = first index with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-021 IDLE: req_ready[grant]=1 combinationally when any req_valid=1; all other req_ready bits 0.
REQ-022 IDLE: on req_valid[grant]&req_ready[grant], latch operands into add_a/add_b and store grant; next state ISSUE.
REQ-023 Outside IDLE: req_ready=0.
REQ-024 ISSUE: add_start=1 for exactly one cycle; clear watchdog counter; next state WAIT.
REQ-025 WAIT: watchdog counter increments each cycle.
REQ-026 WAIT: on add_done=1, capture add_sum into rsp_data, set rsp_err=0; next state RESP.
REQ-027 WAIT: when counter reaches TIMEOUT with add_done=0, set rsp_data=16'h7E00 (qNaN) and rsp_err=1; next state RESP.
REQ-028 If add_done=1 in the same cycle the counter reaches TIMEOUT, add_done wins.
REQ-029 add_done is ignored in IDLE, ISSUE and RESP.
REQ-030 RESP: rsp_valid[stored grant]=1; rsp_data and rsp_err held stable until rsp_ready of that requester is high.
REQ-031 RESP: on accept, rr_ptr <= (grant+1) mod NREQ; next state IDLE.
REQ-032 rsp_ready of non-granted requesters is ignored.
REQ-033 add_a/add_b hold their values from the IDLE handshake until the next handshake.
REQ-034 Latency: handshake cycle N; add_start at N+1; with adder done at N+1+L, rsp_valid at N+2+L.
REQ-035 Back-to-back operation: the earliest next handshake is the cycle after the response accept.
REQ-036 rr_ptr changes only on response accept; timeout results rotate it the same as normal results.

Reset
REQ-037 nrst low forces state IDLE, rr_ptr=0, stored grant=0, add_a=add_b=0, rsp_data=0, rsp_err=0, watchdog=0.
REQ-038 During reset: add_start=0, rsp_valid=0, req_ready=0, busy=0.
REQ-039 Reset asserted mid-operation (ISSUE, WAIT or RESP) abandons the operation with no response.
REQ-040 A late add_done after reset release is ignored per REQ-029.

Verification
REQ-041 Single op: req_valid=4'b0001, a=16'h3C00, b=16'h3C00; adder returns 16'h4000 after 3 cycles -> add_start one cycle after handshake; rsp_valid=4'b0001 with rsp_data=16'h4000, rsp_err=0 one cycle after add_done.
REQ-042 Fairness: req_valid=4'b1111 held, rsp_ready=all 1 -> grants in order 0,1,2,3,0; no requester is granted twice before each other valid requester is granted once.
REQ-043 Timeout: adder never asserts add_done -> rsp_data=16'h7E00, rsp_err=1, TIMEOUT cycles after add_start; then rr_ptr advances.
REQ-044 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; req_ready=0 throughout; no add_start issued.
REQ-045 Tie at limit: add_done asserted exactly when the counter reaches TIMEOUT -> rsp_err=0 and rsp_data=add_sum.
REQ-046 Reset in WAIT: nrst pulsed low, then add_done pulsed -> no rsp_valid; busy=0; next request is granted from index 0.
